keypad_scanner: RTL
===================

Name: keypad_scanner

Overview:
- Player-input front end for the 4x4 mole grid. Produces the `hit` / `hit_index` pair consumed by the round controller.
- Scans an active-low 4x4 matrix keypad one row at a time and synchronises the column inputs.
- Debounces per scan frame and emits exactly one single-cycle `hit` pulse per confirmed key press, with the key's grid index.
- Sits between the board keypad pins and the round/game logic.

Parameters:
- SETTLE_CYCLES, 4, clocks each row is driven before its columns are sampled (minimum 4; board build uses 1000).
- DEBOUNCE_FRAMES, 3, consecutive identical frames needed to confirm a press or a release (minimum 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- row_n  out  4  row drive, active-low, exactly one bit low at all times.
- col_n  in  4  column sense, active-low (external pull-ups), asynchronous.
- hit  out  1  one-cycle pulse on a confirmed new press.
- hit_index  out  4  index of the last confirmed key, computed as row*4+col; held between hits.
- key_held  out  1  high from the hit pulse until the release is confirmed.

Behaviour:
- Reset values:
  - row_n = 4'b1110 (row 0); hit = 0; hit_index = 0; key_held = 0.
  - Synchroniser, settle counter, row counter, candidate, frame counters and FSM are all cleared.
- Reset mid-operation: scan restarts at row 0 the following cycle. A partial confirmation is discarded and no hit is emitted.
- Synchroniser:
  - col_n passes through 2 flops before use.
  - Samples are taken from the synchronised value only.
- Scan timing:
  - The settle counter runs 0..SETTLE_CYCLES-1 per row.
  - On count SETTLE_CYCLES-1, the synchronised columns are captured into that row's 4-bit frame slot, and row_n advances in the order 1110 -> 1101 -> 1011 -> 0111 -> 1110.
  - One frame = 4*SETTLE_CYCLES clocks. There is no idle gap between frames.
- Frame classification, on the row-3 capture cycle:
  - NONE: no bits low.
  - SINGLE(k): exactly one bit low, where k = row*4 + column bit position.
  - MULTI: two or more bits low. MULTI is never a valid key (ghosting guard).
- Debounce FSM, advancing once per frame on the classification:
  - RELEASED:
    - SINGLE(k): cand <= k, cnt <= 1, go to CONFIRM.
    - Otherwise stay.
  - CONFIRM:
    - SINGLE(cand): cnt+1. When cnt+1 == DEBOUNCE_FRAMES, go to HELD, hit_index <= cand, hit pulses.
    - SINGLE(j), j != cand: cand <= j, cnt <= 1, stay.
    - NONE or MULTI: go to RELEASED.
  - HELD:
    - key_held = 1.
    - NONE: rcnt+1. When rcnt+1 == DEBOUNCE_FRAMES, go to RELEASED and key_held <= 0.
    - SINGLE or MULTI: rcnt <= 0. No new hit is possible while in HELD, including a different key.
- Hit timing:
  - hit is registered and is high for exactly the one clock after the confirming row-3 capture cycle (i.e. the first clock of the next frame).
  - hit_index updates on the same edge and is stable while hit is high.
- Counter widths:
  - cnt and rcnt use $clog2(DEBOUNCE_FRAMES+1) bits and saturate-free; they reset on every state transition.
  - The settle counter uses $clog2(SETTLE_CYCLES) bits and wraps to 0.

Test Plan:
All cases use SETTLE_CYCLES=4, DEBOUNCE_FRAMES=3, frame = 16 clocks.
1. Row sweep, no keys, 3 frames -> row_n cycles 1110/1101/1011/0111 with 4 clocks each; hit is never high; key_held = 0.
2. Key row2/col1 (col_n = 1101 while row_n = 1011) held steady from frame 0 -> one hit pulse on the first clock after frame 2's row-3 capture, hit_index = 9, key_held = 1. Release: key_held falls after 3 empty frames.
3. Bounce: key 9 present, absent, present, absent, then steady -> hit only after the 3rd consecutive present frame, hit_index = 9, exactly one pulse.
4. Keys 0 and 5 pressed together for 5 frames -> no hit. Then release key 0 -> hit with hit_index = 5 after 3 SINGLE frames.
5. Hold key 15 for 20 frames -> exactly one hit (index 15). Release 2 frames and re-press -> no hit, key_held stays 1. Release 3 frames, then press 3 frames -> second hit with index 15.
6. rst asserted for 1 clock after 2 confirming frames of key 6 -> no hit, row_n = 1110 on the next clock. A new press still needs 3 full frames.

Source files
------------

// File: rtl/keypad_scanner.sv
// Row-scanning front end for the active-low 4x4 mole keypad: synchronises the columns,
// classifies each scan frame and debounces it into a single hit pulse per confirmed press.
module keypad_scanner #(
    parameter int SETTLE_CYCLES   = 4,
    parameter int DEBOUNCE_FRAMES = 3
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] row_n,
    input  logic [3:0] col_n,
    output logic       hit,
    output logic [3:0] hit_index,
    output logic       key_held
);

    localparam int SW = $clog2(SETTLE_CYCLES);
    localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_LAST    = CW'(DEBOUNCE_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_RELEASED = 2'd0,
        ST_CONFIRM  = 2'd1,
        ST_HELD     = 2'd2
    } state_t;

    function automatic logic [4:0] count_active(input logic [15:0] act);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'd0, act[i]};
        end
        return n;
    endfunction

    function automatic logic [3:0] active_index(input logic [15:0] act);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            idx = act[i] ? 4'(i) : idx;
        end
        return idx;
    endfunction

    logic [3:0]    col_meta_r;
    logic [3:0]    col_sync_r;
    logic [SW-1:0] settle_r;
    logic [1:0]    row_r;
    logic [3:0]    row_n_r;
    logic [11:0]   frame_r;
    state_t        state_r;
    logic [3:0]    cand_r;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] rcnt_r;
    logic          hit_r;
    logic [3:0]    hit_index_r;
    logic          key_held_r;

    logic          capture_s;
    logic          frame_end_s;
    logic [15:0]   active_s;
    logic [4:0]    nlow_s;
    logic [3:0]    key_s;
    logic          is_single_s;
    logic          is_none_s;

    // Row 3 is classified straight from the synchroniser on its capture cycle.
    assign capture_s   = (settle_r == SETTLE_LAST);
    assign frame_end_s = capture_s && (row_r == 2'd3);
    assign active_s    = ~{col_sync_r, frame_r};
    assign nlow_s      = count_active(active_s);
    assign key_s       = active_index(active_s);
    assign is_single_s = (nlow_s == 5'd1);
    assign is_none_s   = (nlow_s == 5'd0);

    assign row_n     = row_n_r;
    assign hit       = hit_r;
    assign hit_index = hit_index_r;
    assign key_held  = key_held_r;

    // Column synchroniser, settle/row counters and per-row frame capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_meta_r <= 4'b1111;
            col_sync_r <= 4'b1111;
            settle_r   <= '0;
            row_r      <= 2'd0;
            row_n_r    <= 4'b1110;
            frame_r    <= 12'hFFF;
        end else begin
            col_meta_r <= col_n;
            col_sync_r <= col_meta_r;
            if (capture_s) begin
                settle_r <= '0;
                row_r    <= row_r + 2'd1;
                row_n_r  <= {row_n_r[2:0], row_n_r[3]};
                case (row_r)
                    2'd0:    frame_r[3:0]  <= col_sync_r;
                    2'd1:    frame_r[7:4]  <= col_sync_r;
                    2'd2:    frame_r[11:8] <= col_sync_r;
                    default: frame_r       <= frame_r;
                endcase
            end else begin
                settle_r <= settle_r + SW'(1);
            end
        end
    end

    // Per-frame debounce FSM with registered hit, index and held outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_RELEASED;
            cand_r      <= 4'd0;
            cnt_r       <= '0;
            rcnt_r      <= '0;
            hit_r       <= 1'b0;
            hit_index_r <= 4'd0;
            key_held_r  <= 1'b0;
        end else begin
            hit_r <= 1'b0;
            if (frame_end_s) begin
                case (state_r)
                    ST_RELEASED: begin
                        if (is_single_s) begin
                            cand_r  <= key_s;
                            cnt_r   <= CW'(1);
                            state_r <= ST_CONFIRM;
                        end
                    end
                    ST_CONFIRM: begin
                        if (is_single_s && (key_s == cand_r)) begin
                            if (cnt_r == CNT_LAST) begin
                                state_r     <= ST_HELD;
                                hit_r       <= 1'b1;
                                hit_index_r <= cand_r;
                                key_held_r  <= 1'b1;
                                cnt_r       <= '0;
                                rcnt_r      <= '0;
                            end else begin
                                cnt_r <= cnt_r + CW'(1);
                            end
                        end else if (is_single_s) begin
                            cand_r <= key_s;
                            cnt_r  <= CW'(1);
                        end else begin
                            state_r <= ST_RELEASED;
                            cnt_r   <= '0;
                        end
                    end
                    ST_HELD: begin
                        if (is_none_s) begin
                            if (rcnt_r == CNT_LAST) begin
                                state_r    <= ST_RELEASED;
                                key_held_r <= 1'b0;
                                rcnt_r     <= '0;
                            end else begin
                                rcnt_r <= rcnt_r + CW'(1);
                            end
                        end else begin
                            rcnt_r <= '0;
                        end
                    end
                    default: begin
                        state_r    <= ST_RELEASED;
                        cnt_r      <= '0;
                        rcnt_r     <= '0;
                        key_held_r <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
